exec_rep_sequencer: RTL and testbench
=====================================

EXEC_REP_SEQUENCER -- requirements
Module: exec_rep_sequencer

Interface
REQ-001 Ports SHALL be, one per line: name  direction  width  meaning; clock and reset first.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 flush  in  1  synchronous abort of the in-flight instruction.
REQ-005 d_valid  in  1  decoded string instruction offered.
REQ-006 d_ready  out  1  sequencer can accept an instruction.
REQ-007 d_rep  in  1  REP prefix present.
REQ-008 d_ecx  in  32  starting ECX.
REQ-009 d_esi  in  32  starting ESI.
REQ-010 d_edi  in  32  starting EDI.
REQ-011 d_opsize  in  3  element size: bit2 = 4 bytes, else bit1 = 2 bytes, else 1 byte.
REQ-012 d_df  in  1  direction flag: 0 = increment, 1 = decrement.
REQ-013 e_valid  out  1  iteration offered to execute.
REQ-014 e_ready  in  1  execute accepts the iteration.
REQ-015 e_esi  out  32  ESI for this iteration.
REQ-016 e_edi  out  32  EDI for this iteration.
REQ-017 e_ecx  out  32  ECX value to write back after this iteration.
REQ-018 e_last  out  1  final beat of the instruction.
REQ-019 e_skip  out  1  beat carries no memory op (REP with ECX = 0).
REQ-020 busy  out  1  instruction in progress (state not IDLE).

Function
REQ-021 The state machine SHALL have two states: IDLE and ISSUE.
REQ-022 d_ready SHALL be 1 only in IDLE; instructions never overlap.
REQ-023 Accept = d_valid & d_ready. On accept, the block SHALL register esi/edi/opsize/df, set step = 1/2/4 per REQ-011, and enter ISSUE.
REQ-024 Remaining count on accept SHALL be: d_rep = 0 -> 1; d_rep = 1 -> d_ecx.
REQ-025 e_valid SHALL be 1 in ISSUE only. First e_valid is the cycle after accept (1-cycle latency).
REQ-026 While e_valid = 1 and e_ready = 0, every e_* output SHALL hold stable.
REQ-027 Non-REP beat: e_ecx = captured d_ecx (unchanged), e_last = 1, e_skip = 0.
REQ-028 REP beat with count > 0: e_ecx = count - 1; e_last = 1 iff count = 1; e_skip = 0.
REQ-029 REP with d_ecx = 0: exactly one beat SHALL issue, with e_skip = 1, e_last = 1, e_ecx = 0, e_esi/e_edi = start values.
REQ-030 On e_valid & e_ready with e_last = 0: esi += step and edi += step (df = 0), or -= step (df = 1); count -= 1; stay in ISSUE.
REQ-031 On e_valid & e_ready with e_last = 1: return to IDLE. d_ready = 1 in the following cycle.
REQ-032 ESI/EDI arithmetic SHALL be modulo 2^32; wrap-around is legal.
REQ-033 d_ecx = 0xFFFFFFFF SHALL run the full count without overflow of the counter.
REQ-034 flush SHALL take priority over any handshake in the same cycle: next state IDLE, e_valid = 0 next cycle. An accept in the flush cycle SHALL be dropped.
REQ-035 The iteration retired in a flush cycle SHALL still count as transferred downstream; the block does not replay it.

Reset
REQ-036 reset SHALL take priority over flush and over all handshakes.
REQ-037 Reset values SHALL be: state IDLE, d_ready = 1, e_valid = 0, busy = 0, e_last = 0, e_skip = 0, e_esi = e_edi = e_ecx = 0.
REQ-038 Reset asserted mid-instruction SHALL abandon the instruction. No beat SHALL issue in the cycle after reset.

Verification
REQ-039 REP MOVSD: ecx = 3, esi = 0x100, edi = 0x200, df = 0, e_ready = 1 -> three beats: (0x100, 0x200, ecx 2), (0x104, 0x204, 1), (0x108, 0x208, 0, last); d_ready = 1 on the next cycle.
REQ-040 REP STOSB: df = 1, ecx = 2, edi = 0x0, e_ready toggling 0/1 -> beats edi 0x0 then 0xFFFFFFFF; outputs hold while stalled.
REQ-041 REP with ecx = 0 -> a single beat with e_skip = 1, e_last = 1, e_ecx = 0.
REQ-042 Non-REP MOVSW: ecx = 5 -> a single beat with e_ecx = 5, e_last = 1; on a later REP MOVSW, step = 2.
REQ-043 Flush in the 2nd beat of an ecx = 10 run -> e_valid = 0 next cycle, d_ready = 1; a simultaneous d_valid is not accepted.
REQ-044 Reset asserted during ISSUE -> all outputs at REQ-037 values next cycle.

Source files
------------

// File: rtl/exec_rep_sequencer.sv
// Sequencer that expands a decoded x86 string instruction (optionally REP-prefixed)
// into one execute beat per element, stepping ESI/EDI and counting ECX down.
module exec_rep_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic        d_rep,
  input  logic [31:0] d_ecx,
  input  logic [31:0] d_esi,
  input  logic [31:0] d_edi,
  input  logic [2:0]  d_opsize,
  input  logic        d_df,
  output logic        e_valid,
  input  logic        e_ready,
  output logic [31:0] e_esi,
  output logic [31:0] e_edi,
  output logic [31:0] e_ecx,
  output logic        e_last,
  output logic        e_skip,
  output logic        busy
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // a producer holding valid keeps its payload stable until that edge, and valid
  // never depends combinationally on ready.
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] esi_q, esi_d;
  logic [31:0] edi_q, edi_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] ecx_q, ecx_d;
  logic [2:0]  step_q, step_d;
  logic        df_q, df_d;
  logic        rep_q, rep_d;

  logic        accept;
  logic        fire;
  logic [2:0]  new_step;
  logic [31:0] step_w;

  always_comb begin
    casez (d_opsize)
      3'b1??:  new_step = 3'd4;
      3'b01?:  new_step = 3'd2;
      default: new_step = 3'd1;
    endcase
  end

  assign step_w  = {29'd0, step_q};
  assign d_ready = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign e_valid = (state_q == ISSUE);
  assign e_esi   = esi_q;
  assign e_edi   = edi_q;
  // cnt_q holds remaining elements including the current beat; zero only for REP with ECX=0.
  assign e_last  = e_valid & (~rep_q | (cnt_q <= 32'd1));
  assign e_skip  = e_valid & rep_q & (cnt_q == 32'd0);
  assign e_ecx   = !rep_q ? ecx_q : ((cnt_q == 32'd0) ? 32'd0 : cnt_q - 32'd1);

  assign accept  = d_valid & d_ready;
  assign fire    = e_valid & e_ready;

  always_comb begin
    state_d = state_q;
    esi_d   = esi_q;
    edi_d   = edi_q;
    cnt_d   = cnt_q;
    ecx_d   = ecx_q;
    step_d  = step_q;
    df_d    = df_q;
    rep_d   = rep_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = ISSUE;
            esi_d   = d_esi;
            edi_d   = d_edi;
            ecx_d   = d_ecx;
            step_d  = new_step;
            df_d    = d_df;
            rep_d   = d_rep;
            cnt_d   = d_rep ? d_ecx : 32'd1;
          end
        end
        ISSUE: begin
          if (fire) begin
            if (e_last) begin
              state_d = IDLE;
            end else begin
              esi_d = df_q ? (esi_q - step_w) : (esi_q + step_w);
              edi_d = df_q ? (edi_q - step_w) : (edi_q + step_w);
              cnt_d = cnt_q - 32'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      esi_q   <= 32'd0;
      edi_q   <= 32'd0;
      cnt_q   <= 32'd0;
      ecx_q   <= 32'd0;
      step_q  <= 3'd0;
      df_q    <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      esi_q   <= esi_d;
      edi_q   <= edi_d;
      cnt_q   <= cnt_d;
      ecx_q   <= ecx_d;
      step_q  <= step_d;
      df_q    <= df_d;
      rep_q   <= rep_d;
    end
  end

endmodule

// File: tb/tb_exec_rep_sequencer.sv
// Directed bench for exec_rep_sequencer: hand-computed beats checked with immediate assertions.
module tb_exec_rep_sequencer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        d_valid;
  logic        d_ready;
  logic        d_rep;
  logic [31:0] d_ecx;
  logic [31:0] d_esi;
  logic [31:0] d_edi;
  logic [2:0]  d_opsize;
  logic        d_df;
  logic        e_valid;
  logic        e_ready;
  logic [31:0] e_esi;
  logic [31:0] e_edi;
  logic [31:0] e_ecx;
  logic        e_last;
  logic        e_skip;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  exec_rep_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_rep    (d_rep),
    .d_ecx    (d_ecx),
    .d_esi    (d_esi),
    .d_edi    (d_edi),
    .d_opsize (d_opsize),
    .d_df     (d_df),
    .e_valid  (e_valid),
    .e_ready  (e_ready),
    .e_esi    (e_esi),
    .e_edi    (e_edi),
    .e_ecx    (e_ecx),
    .e_last   (e_last),
    .e_skip   (e_skip),
    .busy     (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] esi, input logic [31:0] edi,
                          input logic [31:0] ecx, input logic last, input logic skip);
    chk({tag, ".e_valid"}, {31'd0, e_valid}, 32'd1);
    chk({tag, ".d_ready"}, {31'd0, d_ready}, 32'd0);
    chk({tag, ".e_esi"},   e_esi, esi);
    chk({tag, ".e_edi"},   e_edi, edi);
    chk({tag, ".e_ecx"},   e_ecx, ecx);
    chk({tag, ".e_last"},  {31'd0, e_last}, {31'd0, last});
    chk({tag, ".e_skip"},  {31'd0, e_skip}, {31'd0, skip});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".e_valid"}, {31'd0, e_valid}, 32'd0);
    chk({tag, ".d_ready"}, {31'd0, d_ready}, 32'd1);
    chk({tag, ".busy"},    {31'd0, busy},    32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_idle(tag);
    chk({tag, ".e_last"}, {31'd0, e_last}, 32'd0);
    chk({tag, ".e_skip"}, {31'd0, e_skip}, 32'd0);
    chk({tag, ".e_esi"},  e_esi, 32'd0);
    chk({tag, ".e_edi"},  e_edi, 32'd0);
    chk({tag, ".e_ecx"},  e_ecx, 32'd0);
  endtask

  // driver: offer one instruction for exactly one edge
  task automatic offer(input logic rep, input logic [31:0] ecx, input logic [31:0] esi,
                       input logic [31:0] edi, input logic [2:0] opsize, input logic df);
    d_valid  = 1'b1;
    d_rep    = rep;
    d_ecx    = ecx;
    d_esi    = esi;
    d_edi    = edi;
    d_opsize = opsize;
    d_df     = df;
    tick();
    d_valid  = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    d_valid  = 1'b0;
    d_rep    = 1'b0;
    d_ecx    = 32'd0;
    d_esi    = 32'd0;
    d_edi    = 32'd0;
    d_opsize = 3'd0;
    d_df     = 1'b0;
    e_ready  = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();
    chk_reset_vals("post_reset");

    // REP MOVSD, ecx=3, forward
    e_ready = 1'b1;
    offer(1'b1, 32'd3, 32'h100, 32'h200, 3'b100, 1'b0);
    chk({"movsd.busy"}, {31'd0, busy}, 32'd1);
    chk_beat("movsd.b0", 32'h100, 32'h200, 32'd2, 1'b0, 1'b0);
    tick();
    chk_beat("movsd.b1", 32'h104, 32'h204, 32'd1, 1'b0, 1'b0);
    tick();
    chk_beat("movsd.b2", 32'h108, 32'h208, 32'd0, 1'b1, 1'b0);
    tick();
    chk_idle("movsd.done");

    // REP STOSB, df=1, ecx=2, with stalls
    e_ready = 1'b0;
    offer(1'b1, 32'd2, 32'h50, 32'h0, 3'b001, 1'b1);
    chk_beat("stosb.b0", 32'h50, 32'h0, 32'd1, 1'b0, 1'b0);
    tick();
    chk_beat("stosb.b0_hold", 32'h50, 32'h0, 32'd1, 1'b0, 1'b0);
    e_ready = 1'b1;
    tick();
    e_ready = 1'b0;
    chk_beat("stosb.b1", 32'h4F, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    tick();
    chk_beat("stosb.b1_hold", 32'h4F, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    e_ready = 1'b1;
    tick();
    chk_idle("stosb.done");

    // REP with ecx=0: one skip beat
    offer(1'b1, 32'd0, 32'h300, 32'h400, 3'b100, 1'b0);
    chk_beat("ecx0.b0", 32'h300, 32'h400, 32'd0, 1'b1, 1'b1);
    tick();
    chk_idle("ecx0.done");

    // non-REP MOVSW keeps ECX; then REP MOVSW steps by 2
    offer(1'b0, 32'd5, 32'h10, 32'h20, 3'b010, 1'b0);
    chk_beat("movsw.b0", 32'h10, 32'h20, 32'd5, 1'b1, 1'b0);
    tick();
    chk_idle("movsw.done");
    offer(1'b1, 32'd2, 32'h10, 32'h20, 3'b010, 1'b0);
    chk_beat("repmovsw.b0", 32'h10, 32'h20, 32'd1, 1'b0, 1'b0);
    tick();
    chk_beat("repmovsw.b1", 32'h12, 32'h22, 32'd0, 1'b1, 1'b0);
    tick();
    chk_idle("repmovsw.done");

    // flush in 2nd beat of ecx=10; concurrent d_valid dropped
    offer(1'b1, 32'd10, 32'h1000, 32'h2000, 3'b100, 1'b0);
    chk_beat("flush.b0", 32'h1000, 32'h2000, 32'd9, 1'b0, 1'b0);
    tick();
    chk_beat("flush.b1", 32'h1004, 32'h2004, 32'd8, 1'b0, 1'b0);
    flush = 1'b1;
    offer(1'b1, 32'd7, 32'h5000, 32'h6000, 3'b100, 1'b0);
    flush = 1'b0;
    chk_idle("flush.cut");
    tick();
    chk_idle("flush.dropped");

    // flush while idle drops an offered instruction
    flush = 1'b1;
    offer(1'b1, 32'd3, 32'h7000, 32'h8000, 3'b100, 1'b0);
    flush = 1'b0;
    chk_idle("flush_idle");

    // reset during ISSUE, also overriding flush
    offer(1'b1, 32'd4, 32'hA0, 32'hB0, 3'b100, 1'b0);
    chk_beat("rst.b0", 32'hA0, 32'hB0, 32'd3, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("rst.mid");
    tick();
    chk_reset_vals("rst.after");

    // ecx=0xFFFFFFFF with ESI wrap
    offer(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h10, 3'b100, 1'b0);
    chk_beat("wrap.b0", 32'hFFFF_FFFC, 32'h10, 32'hFFFF_FFFE, 1'b0, 1'b0);
    tick();
    chk_beat("wrap.b1", 32'h0, 32'h14, 32'hFFFF_FFFD, 1'b0, 1'b0);
    tick();
    chk_beat("wrap.b2", 32'h4, 32'h18, 32'hFFFF_FFFC, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("wrap.rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
